// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared encodings for the register file
// Contents: FunSel codes, output-select codes, enable-bit mapping helper.
package register_file_pkg;

   typedef enum logic [2:0] {
      DEC      = 3'b000,
      INC      = 3'b001,
      LOAD     = 3'b010,
      CLR      = 3'b011,
      LOAD8    = 3'b100,
      LOAD16   = 3'b101,
      SHL8_INS = 3'b110,
      SEXT16   = 3'b111
   } fun_sel_e;

   localparam logic [2:0] SEL_R1 = 3'd0;
   localparam logic [2:0] SEL_R2 = 3'd1;
   localparam logic [2:0] SEL_R3 = 3'd2;
   localparam logic [2:0] SEL_R4 = 3'd3;
   localparam logic [2:0] SEL_S1 = 3'd4;
   localparam logic [2:0] SEL_S2 = 3'd5;
   localparam logic [2:0] SEL_S3 = 3'd6;
   localparam logic [2:0] SEL_S4 = 3'd7;

   localparam int NUM_REGS = 8;

   // Enable vector indexed by output-select code. RegSel/ScrSel are
   // MSB-first (bit 3 = R1/S1), so the bit order is reversed here.
   function automatic logic [7:0] reg_enables(input logic [3:0] reg_sel,
                                              input logic [3:0] scr_sel);
      logic [7:0] en;
      en = '0;
      for (int k = 0; k < 4; k++) begin
         en[k]     = reg_sel[3-k];
         en[k + 4] = scr_sel[3-k];
      end
      return en;
   endfunction

endpackage

// File: rtl/register_file_general_register.sv
// rtl/register_file_general_register.sv - one register with the per-cycle function set
// Ports: Clock, Reset (async active-low), E (enable), FunSel, I (data), Q (contents).
module general_register
   import register_file_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             E,
   input  logic [2:0]       FunSel,
   input  logic [WIDTH-1:0] I,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (E) begin
         case (FunSel)
            DEC:      q_d = q_q - WIDTH'(1);
            INC:      q_d = q_q + WIDTH'(1);
            LOAD:     q_d = I;
            CLR:      q_d = '0;
            LOAD8:    q_d = WIDTH'(I[7:0]);
            LOAD16:   q_d = WIDTH'(I[15:0]);
            // Byte shift-left with insert; the top byte falls off.
            SHL8_INS: q_d = {q_q[WIDTH-9:0], I[7:0]};
            // Signed operand makes the width cast replicate I[15].
            SEXT16:   q_d = WIDTH'($signed(I[15:0]));
            default:  q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q = q_q;

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - eight-entry register file with two combinational read ports
// Ports: Clock, Reset (async active-low), I (write data), FunSel, RegSel/ScrSel
//        (enables, bit 3 = R1/S1), OutASel/OutBSel (read selects), OutA/OutB.
module register_file
   import register_file_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] I,
   input  logic [2:0]       FunSel,
   input  logic [3:0]       RegSel,
   input  logic [3:0]       ScrSel,
   input  logic [2:0]       OutASel,
   input  logic [2:0]       OutBSel,
   output logic [WIDTH-1:0] OutA,
   output logic [WIDTH-1:0] OutB
);

   logic [NUM_REGS-1:0] en;
   logic [WIDTH-1:0]    q [NUM_REGS];

   assign en = reg_enables(RegSel, ScrSel);

   // Instance k holds the register whose select code is k (R1..R4, S1..S4).
   for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
      general_register #(
         .WIDTH (WIDTH)
      ) u_reg (
         .Clock  (Clock),
         .Reset  (Reset),
         .E      (en[k]),
         .FunSel (FunSel),
         .I      (I),
         .Q      (q[k])
      );
   end

   // Reads see the registered value only, so a same-cycle write is not bypassed.
   assign OutA = q[OutASel];
   assign OutB = q[OutBSel];

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
`timescale 1ns/100ps
module tb_register_file;
   import register_file_pkg::*;

   localparam int WIDTH = 32;

   logic             Clock = 1'b0;
   logic             Reset;
   logic [WIDTH-1:0] I;
   logic [2:0]       FunSel;
   logic [3:0]       RegSel;
   logic [3:0]       ScrSel;
   logic [2:0]       OutASel;
   logic [2:0]       OutBSel;
   logic [WIDTH-1:0] OutA;
   logic [WIDTH-1:0] OutB;

   int vectors     = 0;
   int miscompares = 0;

   logic [WIDTH-1:0] exp_q [8];

   register_file #(.WIDTH(WIDTH)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .I       (I),
      .FunSel  (FunSel),
      .RegSel  (RegSel),
      .ScrSel  (ScrSel),
      .OutASel (OutASel),
      .OutBSel (OutBSel),
      .OutA    (OutA),
      .OutB    (OutB)
   );

   always #10 Clock = ~Clock;

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Rising edge, then 1 ns of settling; enables drop so later reads are stable.
   task automatic tick();
      @(posedge Clock);
      #1;
      RegSel = 4'b0000;
      ScrSel = 4'b0000;
   endtask

   // Walks all eight selects on both ports (A ascending, B descending) in 8 ns.
   task automatic check_all(input string tag);
      for (int k = 0; k < 8; k++) begin
         OutASel = 3'(k);
         OutBSel = 3'(7 - k);
         #1;
         check($sformatf("%s A sel%0d", tag, k), OutA, exp_q[k]);
         check($sformatf("%s B sel%0d", tag, 7 - k), OutB, exp_q[7 - k]);
      end
   endtask

   task automatic apply(input logic [2:0] fs, input logic [3:0] rs,
                        input logic [3:0] ss, input logic [WIDTH-1:0] data);
      FunSel = fs;
      RegSel = rs;
      ScrSel = ss;
      I      = data;
      tick();
   endtask

   initial begin
      Reset   = 1'b0;
      I       = '0;
      FunSel  = CLR;
      RegSel  = 4'b0000;
      ScrSel  = 4'b0000;
      OutASel = SEL_R1;
      OutBSel = SEL_R1;

      #1;
      for (int k = 0; k < 8; k++) exp_q[k] = '0;
      check_all("por");

      // Edges while reset is held must not load anything.
      FunSel = LOAD;
      RegSel = 4'b1111;
      ScrSel = 4'b1111;
      I      = 32'hCAFEF00D;
      tick();
      check_all("edge_in_reset");
      #2;
      Reset = 1'b1;

      // Fill everything, then pulse reset between edges.
      apply(LOAD, 4'b1111, 4'b1111, 32'hDEADBEEF);
      for (int k = 0; k < 8; k++) exp_q[k] = 32'hDEADBEEF;
      check_all("fill");
      Reset = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) exp_q[k] = '0;
      check_all("async_rst");
      Reset = 1'b1;

      // Broadcast load to R1, R3, S4.
      apply(LOAD, 4'b1010, 4'b0001, 32'h12345678);
      exp_q[SEL_R1] = 32'h12345678;
      exp_q[SEL_R3] = 32'h12345678;
      exp_q[SEL_S4] = 32'h12345678;
      check_all("bcast");

      // Wrap on R2.
      apply(CLR, 4'b0100, 4'b0000, 32'hFFFFFFFF);
      apply(DEC, 4'b0100, 4'b0000, '0);
      OutASel = SEL_R2; #1;
      check("dec_wrap", OutA, 32'hFFFFFFFF);
      apply(INC, 4'b0100, 4'b0000, '0);
      OutASel = SEL_R2; #1;
      check("inc_wrap", OutA, 32'h00000000);

      // Partial and sign loads on S1.
      apply(LOAD8, 4'b0000, 4'b1000, 32'hFFFF8081);
      OutASel = SEL_S1; #1;
      check("load8", OutA, 32'h00000081);
      apply(LOAD16, 4'b0000, 4'b1000, 32'hFFFF8081);
      OutASel = SEL_S1; #1;
      check("load16", OutA, 32'h00008081);
      apply(SEXT16, 4'b0000, 4'b1000, 32'hFFFF8081);
      OutASel = SEL_S1; #1;
      check("sext16", OutA, 32'hFFFF8081);

      // Shift-insert on S2.
      apply(LOAD, 4'b0000, 4'b0100, 32'h11223344);
      apply(SHL8_INS, 4'b0000, 4'b0100, 32'h000000AB);
      OutBSel = SEL_S2; #1;
      check("shl8", OutB, 32'h223344AB);

      // Read-during-write on R4 through both ports.
      apply(LOAD, 4'b0001, 4'b0000, 32'd5);
      FunSel  = LOAD;
      RegSel  = 4'b0001;
      I       = 32'd9;
      OutASel = SEL_R4;
      OutBSel = SEL_R4;
      #1;
      check("rdw_old A", OutA, 32'd5);
      check("rdw_old B", OutB, 32'd5);
      tick();
      check("rdw_new A", OutA, 32'd9);
      check("rdw_new B", OutB, 32'd9);

      // Nothing enabled: CLR must not touch anything.
      apply(CLR, 4'b0000, 4'b0000, '0);
      exp_q[SEL_R1] = 32'h12345678;
      exp_q[SEL_R2] = 32'h00000000;
      exp_q[SEL_R3] = 32'h12345678;
      exp_q[SEL_R4] = 32'd9;
      exp_q[SEL_S1] = 32'hFFFF8081;
      exp_q[SEL_S2] = 32'h223344AB;
      exp_q[SEL_S3] = 32'h00000000;
      exp_q[SEL_S4] = 32'h12345678;
      check_all("hold");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/register_file.md
# register_file

Eight-entry, 32-bit register file: four general registers (R1–R4) and four scratch registers (S1–S4). It sits directly upstream of the arithmetic logic unit and drives that unit's A and B operand buses through two independent read ports. Every selected register applies the same per-cycle function: load, partial load, shift-in, increment, decrement or clear. Writes take effect on the clock edge; reads are combinational.

## Interface
Parameters:
- WIDTH, 32: register and port width. Must be ≥ 16. Partial-load functions always act on bits [15:0] / [7:0].

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset. Clears all eight registers.
- I  in  WIDTH  write data, shared by all registers.
- FunSel  in  3  function applied to every enabled register this cycle.
- RegSel  in  4  general-register enables, active-high. Bit 3 = R1, bit 2 = R2, bit 1 = R3, bit 0 = R4.
- ScrSel  in  4  scratch-register enables, active-high. Bit 3 = S1 … bit 0 = S4.
- OutASel  in  3  port-A source: 000 = R1, 001 = R2, 010 = R3, 011 = R4, 100 = S1, 101 = S2, 110 = S3, 111 = S4.
- OutBSel  in  3  port-B source, same encoding as OutASel.
- OutA  out  WIDTH  selected register value (feeds ALU A).
- OutB  out  WIDTH  selected register value (feeds ALU B).

## Operation
- An enabled register Q is updated on the clock edge as follows:
  - 000: Q ← Q − 1, modulo 2^WIDTH (0 → all-ones).
  - 001: Q ← Q + 1, modulo 2^WIDTH (all-ones → 0).
  - 010: Q ← I.
  - 011: Q ← 0.
  - 100: Q ← zero-extended I[7:0].
  - 101: Q ← zero-extended I[15:0].
  - 110: Q ← {Q[WIDTH-9:0], I[7:0]}. This is a byte shift-left with insert; the top byte is discarded.
  - 111: Q ← sign-extended I[15:0] (I[15] replicated into bits WIDTH-1:16).
- A register whose enable bit is 0 holds its value, whatever FunSel is.
- Any combination of the eight enables may be active at once. All enabled registers apply the same FunSel to their own Q.
- OutA and OutB are purely combinational muxes of the current Q values. Both ports may select the same register.
- No flags and no error outputs are produced. Arithmetic wraps silently.

## Timing
- Reset asserted (Reset = 0): all Q = 0 immediately, without waiting for a clock edge. OutA = OutB = 0 while reset is held.
- Reset deasserted mid-sequence: the first update happens on the first rising edge after Reset returns to 1. Edges during reset are ignored.
- Write-to-read latency is one cycle. A value written at edge n is visible on OutA/OutB after edge n.
- A read of a register in the same cycle it is being written returns the old value; there is no bypass.
- Select changes propagate to OutA/OutB combinationally, with zero cycles of latency.
- Q values are always fully defined; there are no X states after reset.

## Structure
- Shared package holds:
  - FunSel encoding constants (DEC, INC, LOAD, CLR, LOAD8, LOAD16, SHL8_INS, SEXT16).
  - Output-select codes (SEL_R1 … SEL_S4).
  - The RegSel/ScrSel bit-to-register mapping.
- One sub-module, general_register, contains:
  - Ports: Clock, Reset, E, FunSel, I, Q.
  - All function logic.
- register_file instantiates general_register eight times and adds the two 8:1 output muxes.

## Test plan
- Reset: load all registers with 0xDEADBEEF, then pulse Reset low between edges. Required: OutA and OutB read 0 for every select value, before any clock edge.
- Broadcast load: FunSel = 010, I = 0x12345678, RegSel = 1010, ScrSel = 0001. Required: R1, R3 and S4 = 0x12345678; R2, R4, S1, S2 and S3 = 0.
- Wrap: clear R2, then apply DEC for one cycle. Required: R2 = 0xFFFFFFFF. Then apply INC. Required: R2 = 0x00000000.
- Partial and sign loads, each with I = 0xFFFF8081 applied to S1:
  - LOAD8 → 0x00000081.
  - LOAD16 → 0x00008081.
  - SEXT16 → 0xFFFF8081.
- Shift-insert: S2 = 0x11223344, FunSel = 110, I = 0x000000AB. Required: S2 = 0x223344AB.
- Read-during-write and dual port:
  - Start with R4 = 5; load R4 with 9, OutASel = OutBSel = 011. Required: both ports show 5 until the edge and 9 after it.
  - Enables all 0 with FunSel = 011. Required: no register changes.
